// File: rtl/window_deserializer.sv
// Rebuilds one WINDOW_WIDTH-bit HOG window (plus pyramid-level metadata) from a burst of BUS_WIDTH-bit beats.
// Optional build macro WINDOW_DESER_META_CHECK_EN adds a sticky per-beat metadata consistency check.
module window_deserializer #(
  parameter int WINDOW_WIDTH = 1152,
  parameter int BUS_WIDTH    = 128,
  parameter int META_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stream_valid,
  input  logic [BUS_WIDTH-1:0]    stream,
  output logic                    stream_ready,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic [WINDOW_WIDTH-1:0] window,
  output logic [META_WIDTH-1:0]   metadata,
  output logic                    meta_error
);

  localparam int DATA_PORTION = BUS_WIDTH - META_WIDTH;
  localparam int DATA_REMAIN  = WINDOW_WIDTH % DATA_PORTION;
  localparam int NUM_BEATS    = WINDOW_WIDTH / DATA_PORTION + 1;
  localparam int CNT_W        = $clog2(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      beat_cnt;
  logic [META_WIDTH-1:0] beat_meta;
  logic                  accept;

  assign beat_meta = stream[BUS_WIDTH-1 -: META_WIDTH];
  assign accept    = stream_valid && stream_ready;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next   = state;
    stream_ready = 1'b0;
    window_valid = 1'b0;
    case (state)
      COLLECT: begin
        stream_ready = 1'b1;
        if (accept && beat_cnt == LAST_BEAT) state_next = HOLD;
      end
      HOLD: begin
        window_valid = 1'b1;
        if (window_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      beat_cnt <= '0;
      metadata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) metadata <= beat_meta;
      end
    end
  end

  // NOTE: the window buffer is an ordinary register bank, so it takes a reset value like any other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
    end else if (accept) begin
      // Full slices use constant part-selects; the short last slice is handled separately.
      for (int k = 0; k < NUM_BEATS - 1; k++) begin
        if (beat_cnt == CNT_W'(k))
          window[k*DATA_PORTION +: DATA_PORTION] <= stream[DATA_PORTION-1:0];
      end
      if (beat_cnt == LAST_BEAT)
        window[(NUM_BEATS-1)*DATA_PORTION +: DATA_REMAIN] <= stream[DATA_REMAIN-1:0];
    end
  end

`ifdef WINDOW_DESER_META_CHECK_EN
  // Beats after the first must carry the pyramid level captured from beat 0; the flag is sticky.
  always_ff @(posedge clk) begin
    if (rst)
      meta_error <= 1'b0;
    else if (accept && beat_cnt != '0 && beat_meta != metadata)
      meta_error <= 1'b1;
  end
`else
  assign meta_error = 1'b0;
`endif

endmodule

// File: tb/tb_window_deserializer.sv
// Scoreboard bench for window_deserializer: directed scenarios plus randomized bursts with bubbles and backpressure.
module tb_window_deserializer;

  localparam int WW = 1152;
  localparam int BW = 128;
  localparam int MW = 3;
  localparam int DP = BW - MW;
  localparam int NB = WW / DP + 1;
`ifdef WINDOW_DESER_META_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          stream_valid;
  logic [BW-1:0] stream;
  logic          stream_ready;
  logic          window_valid;
  logic          window_ready;
  logic [WW-1:0] window;
  logic [MW-1:0] metadata;
  logic          meta_error;

  window_deserializer dut (
    .clk          (clk),
    .rst          (rst),
    .stream_valid (stream_valid),
    .stream       (stream),
    .stream_ready (stream_ready),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .window       (window),
    .metadata     (metadata),
    .meta_error   (meta_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] win;
    logic [MW-1:0] meta;
  } exp_t;

  exp_t          sb[$];
  logic [BW-1:0] beats[NB];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            hs_cycle;
  bit            rand_mode = 1'b0;
  bit            exp_meta_err = 1'b0;
  logic [MW-1:0] burst_meta;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare wide windows word by word and report the first differing 32-bit word.
  task automatic check_win(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    int bad = 0;
    for (int w = 0; w < WW / 32; w++) begin
      if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
        bad = w;
        break;
      end
    end
    check($sformatf("%s word%0d", name, bad), 128'(act[bad*32 +: 32]), 128'(exp[bad*32 +: 32]));
  endtask

  // Reference: window bit i comes from bit (i mod DP) of beat (i div DP).
  function automatic exp_t model();
    exp_t e;
    for (int i = 0; i < WW; i++) e.win[i] = beats[i / DP][i % DP];
    e.meta = beats[0][BW-1 -: MW];
    return e;
  endfunction

  // Monitor: every window handshake pops one expected window.
  always @(negedge clk) begin
    if (!rst && window_valid && window_ready) begin
      if (sb.size() == 0) begin
        check("unexpected window", 128'(1), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_win("window", window, e.win);
        check("metadata", 128'(metadata), 128'(e.meta));
        check("meta_error at window", 128'(meta_error), 128'(exp_meta_err));
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] b, input int k);
    bit ok = 1'b0;
    stream_valid = 1'b1;
    stream = b;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (stream_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rand_mode) window_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) check("beat accept timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    if (k == 0) begin
      hs_cycle = cyc;
      burst_meta = b[BW-1 -: MW];
    end else if (CHECK_EN && b[BW-1 -: MW] != burst_meta) begin
      exp_meta_err = 1'b1;
    end
    if (rand_mode) window_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycles(input int n);
    stream_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("gap window_valid", 128'(window_valid), 128'(0));
      check("gap stream_ready", 128'(stream_ready), 128'(1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_burst(input int gap_a, input int gap_b, input int gap_len);
    sb.push_back(model());
    for (int k = 0; k < NB; k++) begin
      send_beat(beats[k], k);
      if (k == gap_a || k == gap_b) idle_cycles(gap_len);
      else if (rand_mode && k < NB - 1 && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    stream_valid = 1'b0;
  endtask

  task automatic fill_pattern(input logic [MW-1:0] meta);
    for (int k = 0; k < NB - 1; k++) begin
      logic [127:0] rep;
      rep = {16{8'(k)}};
      beats[k] = {meta, rep[DP-1:0]};
    end
    beats[NB-1] = {meta, {(DP - 27){1'b1}}, 27'h5A5A5A5};
  endtask

  task automatic fill_random(input logic [MW-1:0] meta);
    for (int k = 0; k < NB; k++) begin
      beats[k] = {$urandom, $urandom, $urandom, $urandom};
      beats[k][BW-1 -: MW] = meta;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stream_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst window_valid", 128'(window_valid), 128'(0));
    check("rst window", 128'(window[127:0] | window[WW-1 -: 128]), 128'(0));
    check("rst metadata", 128'(metadata), 128'(0));
    check("rst meta_error", 128'(meta_error), 128'(0));
    check("rst stream_ready", 128'(stream_ready), 128'(1));
    sb.delete();
    exp_meta_err = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int first_start;
    logic [WW-1:0] held;
    bit stable;
    rst = 1'b1;
    stream_valid = 1'b0;
    stream = '0;
    window_ready = 1'b0;
    #1;
    do_reset();

    // Single window, then backpressure for 20 cycles.
    fill_pattern(3'd5);
    sb.push_back(model());
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) check("valid before last beat", 128'(window_valid), 128'(0));
      send_beat(beats[k], k);
    end
    stream_valid = 1'b0;
    check("valid after last beat", 128'(window_valid), 128'(1));
    check("last slice", 128'(window[WW-1 -: 27]), 128'(27'h5A5A5A5));
    held = window;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stream_ready !== 1'b0 || window_valid !== 1'b1 || window !== held || metadata !== 3'd5)
        stable = 1'b0;
    end
    check("backpressure hold", 128'(stable), 128'(1));
    @(posedge clk);
    #1;
    window_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready after release", 128'(stream_ready), 128'(1));

    // Bubbles after beats 2 and 7 must give the same window.
    send_burst(2, 7, 3);

    // Back-to-back windows with meta 1 then 6.
    fill_random(3'd1);
    send_burst(-1, -1, 0);
    first_start = hs_cycle;
    fill_random(3'd6);
    send_burst(-1, -1, 0);
    check("back-to-back period", 128'(hs_cycle - first_start), 128'(NB + 1));
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-burst: 4 beats, reset, then a full new burst.
    fill_random(3'd4);
    for (int k = 0; k < 4; k++) send_beat(beats[k], k);
    do_reset();
    fill_random(3'd3);
    send_burst(-1, -1, 0);
    repeat (3) @(posedge clk);
    #1;

    // Metadata consistency: beat 0 meta 2, beat 4 meta 3.
    fill_random(3'd2);
    beats[4][BW-1 -: MW] = 3'd3;
    sb.push_back(model());
    for (int k = 0; k < NB; k++) begin
      if (k == 4) check("meta_error before bad beat", 128'(meta_error), 128'(0));
      send_beat(beats[k], k);
      if (k == 4) check("meta_error after bad beat", 128'(meta_error), 128'(CHECK_EN));
    end
    stream_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("meta_error sticky", 128'(meta_error), 128'(CHECK_EN));
    do_reset();

    // Randomized bursts with bubbles and random consumer backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 12; n++) begin
      fill_random(3'($urandom_range(0, 7)));
      send_burst(-1, -1, 0);
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
      window_ready = 1'($urandom_range(0, 1));
    end
    rand_mode = 1'b0;
    window_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
